// File: rtl/philv_pkg.sv
// Shared definitions for the PhilosophyV control/execute slice:
// opcodes, ALU function codes, operand-B select codes and controller states.
package philv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam int ALU_FUNCT_WIDTH = 4;

    // {alt, funct3}; alt only matters for ADD/SUB and SRL/SRA
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SUB  = 4'b1000;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SLL  = 4'b0001;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SLT  = 4'b0010;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SLTU = 4'b0011;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_XOR  = 4'b0100;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SRL  = 4'b0101;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SRA  = 4'b1101;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_OR   = 4'b0110;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_AND  = 4'b0111;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;
    localparam logic [1:0] SRC_B_ZERO = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4
    } state_e;

endpackage

// File: rtl/philv_alu.sv
// Combinational RV32I integer ALU: z = funct(x, y), wrapping arithmetic, no flags.
module philv_alu
    import philv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [ALU_FUNCT_WIDTH-1:0] funct,
    input  logic [W-1:0]               x,
    input  logic [W-1:0]               y,
    output logic [W-1:0]               z
);

    localparam int SHAMT_W = $clog2(W);

    logic signed [W-1:0] xs;
    logic signed [W-1:0] ys;
    logic [SHAMT_W-1:0]  shamt;

    assign xs    = x;
    assign ys    = y;
    assign shamt = y[SHAMT_W-1:0];

    always_comb begin
        z = '0;
        case (funct[2:0])
            3'b000:  z = funct[3] ? (x - y) : (x + y);
            3'b001:  z = x << shamt;
            3'b010:  z = {{(W-1){1'b0}}, (xs < ys)};
            3'b011:  z = {{(W-1){1'b0}}, (x < y)};
            3'b100:  z = x ^ y;
            3'b101:  z = funct[3] ? W'(xs >>> shamt) : (x >> shamt);
            3'b110:  z = x | y;
            default: z = x & y;
        endcase
    end

endmodule

// File: rtl/philv_ctrl_exec_unit.sv
// PhilosophyV multicycle control/execute slice: 5-state controller, field decoder
// and ALU operand muxing between the IF register and the register file.
module philv_ctrl_exec_unit
    import philv_pkg::*;
#(
    parameter int BUS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr,
    input  logic [BUS_WIDTH-1:0] pc,
    input  logic [BUS_WIDTH-1:0] rs1_data,
    input  logic [BUS_WIDTH-1:0] rs2_data,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 reg_wr_ena,
    output logic [4:0]           rs1_addr,
    output logic [4:0]           rs2_addr,
    output logic [4:0]           rd_addr,
    output logic [BUS_WIDTH-1:0] immed,
    output logic [BUS_WIDTH-1:0] alu_result
);

    state_e state_q;
    state_e state_d;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       is_op;
    logic       is_op_imm;
    logic       alt;
    logic [1:0] exec_src_b;

    logic                       src_a_rs1;
    logic [1:0]                 src_b;
    logic                       override;
    logic [ALU_FUNCT_WIDTH-1:0] funct;
    logic [BUS_WIDTH-1:0]       alu_x;
    logic [BUS_WIDTH-1:0]       alu_y;

    assign opcode    = instr[6:0];
    assign f3        = instr[14:12];
    assign rd_addr   = instr[11:7];
    assign rs1_addr  = instr[19:15];
    assign rs2_addr  = instr[24:20];
    assign immed     = {{(BUS_WIDTH-12){instr[31]}}, instr[31:20]};

    assign is_op     = (opcode == OPC_OP);
    assign is_op_imm = (opcode == OPC_OP_IMM);

    // OP-IMM only honours bit 30 for SRAI so that ADDI never turns into a subtract
    assign alt        = is_op ? instr[30] : (is_op_imm && (f3 == 3'b101)) ? instr[30] : 1'b0;
    assign exec_src_b = is_op ? SRC_B_RS2 : SRC_B_IMM;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_wr_ena = 1'b0;
        src_a_rs1  = 1'b1;
        src_b      = exec_src_b;
        override   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                src_a_rs1 = 1'b0;
                src_b     = SRC_B_FOUR;
                override  = 1'b1;
                state_d   = ST_DECODE;
            end
            ST_DECODE: begin
                src_a_rs1 = 1'b0;
                src_b     = SRC_B_FOUR;
                override  = 1'b1;
                state_d   = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                state_d = ST_MEMORY;
            end
            ST_MEMORY: begin
                state_d = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                reg_wr_ena = is_op | is_op_imm;
                state_d    = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_comb begin
        alu_y = '0;
        case (src_b)
            SRC_B_RS2:  alu_y = rs2_data;
            SRC_B_FOUR: alu_y = BUS_WIDTH'(4);
            SRC_B_IMM:  alu_y = immed;
            default:    alu_y = '0;
        endcase
    end

    assign alu_x = src_a_rs1 ? rs1_data : pc;
    assign funct = override ? ALU_ADD : {alt, f3};

    philv_alu #(
        .W (BUS_WIDTH)
    ) u_alu (
        .funct (funct),
        .x     (alu_x),
        .y     (alu_y),
        .z     (alu_result)
    );

endmodule

// File: tb/tb_philv_ctrl_exec_unit.sv
// Scoreboard bench for philv_ctrl_exec_unit: directed cases plus random instructions
// checked against a phase-counting reference model.
module tb_philv_ctrl_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, pc, rs1_data, rs2_data;
    logic        pc_write, ir_write, reg_wr_ena;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] immed, alu_result;

    always #5 clk = ~clk;

    philv_ctrl_exec_unit #(.BUS_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .pc         (pc),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .reg_wr_ena (reg_wr_ena),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rd_addr    (rd_addr),
        .immed      (immed),
        .alu_result (alu_result)
    );

    typedef struct {
        string       name;
        logic        pcw, irw, rwe;
        logic [4:0]  ra1, ra2, rda;
        logic [31:0] imm, alu;
        bit          chk_alu;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   phase = 0;

    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ext;
        int          sh;
        sh = int'(b[4:0]);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                ext = alt ? {{32{a[31]}}, a} : {32'd0, a};
                ext = ext >> sh;
                return ext[31:0];
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic exp_t model(input int ph, input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] a, input logic [31:0] b, input string nm);
        exp_t e;
        bit   op, opi;
        logic [31:0] imm;
        op  = (ins[6:0] == 7'b0110011);
        opi = (ins[6:0] == 7'b0010011);
        imm = {{20{ins[31]}}, ins[31:20]};
        e.name    = $sformatf("%s/ph%0d", nm, ph);
        e.pcw     = (ph == 0);
        e.irw     = (ph == 0);
        e.rwe     = (ph == 4) && (op || opi);
        e.ra1     = ins[19:15];
        e.ra2     = ins[24:20];
        e.rda     = ins[11:7];
        e.imm     = imm;
        e.chk_alu = 1'b1;
        if (ph < 2) e.alu = p + 32'd4;
        else if (op) e.alu = ref_alu(ins[14:12], ins[30], a, b);
        else if (opi) e.alu = ref_alu(ins[14:12], (ins[14:12] == 3'd5) && ins[30], a, imm);
        else begin
            e.alu     = '0;
            e.chk_alu = 1'b0;
        end
        return e;
    endfunction

    task automatic step(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] b, input logic r, input string nm);
        instr = ins; pc = p; rs1_data = a; rs2_data = b; rst = r;
        sb.push_back(model(phase, ins, p, a, b, nm));
        @(posedge clk); #1;
        phase = r ? 0 : (phase + 1) % 5;
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic [31:0] p,
                             input logic [31:0] a, input logic [31:0] b, input string nm);
        for (int k = 0; k < 5; k++) step(ins, p, a, b, 1'b0, nm);
    endtask

    task automatic check(input string nm, input string field, input logic [31:0] got,
                         input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s %s: got %h expected %h", nm, field, got, want);
        end
    endtask

    // Monitor: compares whatever the stimulus queued for this cycle
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, "pc_write",   {31'd0, pc_write},   {31'd0, e.pcw});
            check(e.name, "ir_write",   {31'd0, ir_write},   {31'd0, e.irw});
            check(e.name, "reg_wr_ena", {31'd0, reg_wr_ena}, {31'd0, e.rwe});
            check(e.name, "rs1_addr",   {27'd0, rs1_addr},   {27'd0, e.ra1});
            check(e.name, "rs2_addr",   {27'd0, rs2_addr},   {27'd0, e.ra2});
            check(e.name, "rd_addr",    {27'd0, rd_addr},    {27'd0, e.rda});
            check(e.name, "immed",      immed,               e.imm);
            if (e.chk_alu) check(e.name, "alu_result", alu_result, e.alu);
        end
    end

    initial begin
        logic [31:0] ins, p;
        int          sel;
        instr = 32'h0000_0013; pc = 32'h100; rs1_data = '0; rs2_data = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        phase = 0;

        // reset held: FETCH outputs with pc=0x100
        step(32'h0000_0013, 32'h100, 32'd0, 32'd0, 1'b1, "reset");
        run_instr(32'h0000_0013, 32'h100, 32'd0, 32'd0, "nop_walk");
        run_instr(32'h0020_81B3, 32'h104, 32'd7, 32'd5, "add");
        run_instr(32'h4020_81B3, 32'h108, 32'd5, 32'd7, "sub");
        run_instr(32'h0020_A1B3, 32'h10C, 32'd5, 32'd7, "slt");
        run_instr(32'h0020_B1B3, 32'h110, 32'hFFFF_FFFF, 32'd1, "sltu");
        run_instr(32'hFFF0_0093, 32'h114, 32'd0, 32'd0, "addi_m1");
        run_instr(32'h4040_D093, 32'h118, 32'h8000_0000, 32'd0, "srai4");
        run_instr(32'h0000_2083, 32'h11C, 32'd3, 32'd9, "load_nop");

        // reset during EXECUTE restarts at FETCH
        step(32'h0020_81B3, 32'h120, 32'd1, 32'd2, 1'b0, "midrst");
        step(32'h0020_81B3, 32'h120, 32'd1, 32'd2, 1'b0, "midrst");
        step(32'h0020_81B3, 32'h120, 32'd1, 32'd2, 1'b1, "midrst");
        run_instr(32'h0020_81B3, 32'h200, 32'd1, 32'd2, "after_rst");

        for (int n = 0; n < 200; n++) begin
            ins = $urandom;
            p   = $urandom;
            sel = int'($urandom_range(0, 6));
            if (sel < 3) ins[6:0] = 7'b0110011;
            else if (sel < 6) ins[6:0] = 7'b0010011;
            else if (ins[6:0] == 7'b0110011 || ins[6:0] == 7'b0010011) ins[6:0] = 7'b0000011;
            for (int k = 0; k < 5; k++) begin
                // occasional shift-boundary operands
                if ($urandom_range(0, 7) == 0) step(ins, p, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rnd");
                else step(ins, p, $urandom, $urandom, 1'b0, "rnd");
            end
        end

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
